// File: rtl/sobel5_linebuf.sv
// Raster-to-column line buffer feeding the 5x5 Sobel stage: N-1 cascaded line delays.
// Optional macro SOBEL5_LINEBUF_EDGE_REPLICATE_EN replicates the top row instead of zero padding.
module sobel5_linebuf #(
    parameter int unsigned N     = 5,
    parameter int unsigned DW    = 9,
    parameter int unsigned IMG_W = 640
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            pix_vld,
    input  logic            pix_sof,
    input  logic            pix_eol,
    input  logic [DW-1:0]   pix_data,
    output logic [N*DW-1:0] dout,
    output logic            dout_vld,
    output logic            dout_full,
    output logic            ovf_err
);

    localparam int unsigned   CW       = $clog2(IMG_W);
    localparam int unsigned   RW       = $clog2(N);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROWS_MAX = RW'(N - 1);

    logic [DW-1:0]   r_mem [N-1][IMG_W];
    logic [CW-1:0]   r_col_ptr;
    logic [RW-1:0]   r_rows_done;
    logic [N*DW-1:0] r_dout;
    logic            r_dout_vld;
    logic            r_dout_full;
    logic            r_ovf_err;

    logic [CW-1:0]   w_addr;
    logic [RW-1:0]   w_rows;
    logic [DW-1:0]   w_rd [N-1];
    logic [N*DW-1:0] w_dout;
    logic            w_at_end;
    logic            w_ovf;
    logic            w_eol;

    // A start-of-frame pixel behaves as column 0 of row 0 regardless of current state.
    assign w_addr   = pix_sof ? '0 : r_col_ptr;
    assign w_rows   = pix_sof ? '0 : r_rows_done;
    assign w_at_end = (w_addr == LAST_COL);
    assign w_ovf    = w_at_end && !pix_eol;
    assign w_eol    = pix_eol || w_at_end;

    for (genvar k = 0; k < N - 1; k++) begin : g_rd
        assign w_rd[k] = r_mem[k][w_addr];
    end

    // Read-before-write: each line shifts its old pixel one line further up.
    always_ff @(posedge clk) begin
        if (pix_vld) begin
            r_mem[0][w_addr] <= pix_data;
            for (int k = 1; k < int'(N) - 1; k++) begin
                r_mem[k][w_addr] <= w_rd[k-1];
            end
        end
    end

    assign w_dout[(N-1)*DW +: DW] = pix_data;

`ifdef SOBEL5_LINEBUF_EDGE_REPLICATE_EN
    logic [DW-1:0] w_top;

    always_comb begin
        w_top = pix_data;
        for (int k = 0; k < int'(N) - 1; k++) begin
            if (w_rows == RW'(k + 1)) begin
                w_top = w_rd[k];
            end
        end
    end

    for (genvar k = 0; k < N - 1; k++) begin : g_slot
        assign w_dout[(N-2-k)*DW +: DW] = (w_rows > RW'(k)) ? w_rd[k] : w_top;
    end
`else
    for (genvar k = 0; k < N - 1; k++) begin : g_slot
        assign w_dout[(N-2-k)*DW +: DW] = (w_rows > RW'(k)) ? w_rd[k] : '0;
    end
`endif

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            r_dout      <= '0;
            r_dout_vld  <= 1'b0;
            r_dout_full <= 1'b0;
            r_ovf_err   <= 1'b0;
            r_col_ptr   <= '0;
            r_rows_done <= '0;
        end else begin
            r_dout_vld <= pix_vld;
            if (pix_vld) begin
                r_dout      <= w_dout;
                r_dout_full <= (w_rows == ROWS_MAX);
                if (pix_sof) begin
                    r_ovf_err <= 1'b0;
                end else if (w_ovf) begin
                    r_ovf_err <= 1'b1;
                end
                if (w_eol) begin
                    r_col_ptr   <= '0;
                    r_rows_done <= (w_rows == ROWS_MAX) ? w_rows : w_rows + 1'b1;
                end else begin
                    r_col_ptr   <= w_addr + 1'b1;
                    r_rows_done <= w_rows;
                end
            end
        end
    end

    assign dout      = r_dout;
    assign dout_vld  = r_dout_vld;
    assign dout_full = r_dout_full;
    assign ovf_err   = r_ovf_err;

endmodule

// File: tb/tb_sobel5_linebuf.sv
// Scoreboard bench for sobel5_linebuf; honours SOBEL5_LINEBUF_EDGE_REPLICATE_EN like the DUT.
module tb_sobel5_linebuf;

    localparam int N     = 5;
    localparam int DW    = 9;
    localparam int IMG_W = 16;

    logic            clk = 1'b0;
    logic            rst_b;
    logic            pix_vld, pix_sof, pix_eol;
    logic [DW-1:0]   pix_data;
    logic [N*DW-1:0] dout;
    logic            dout_vld, dout_full, ovf_err;

    sobel5_linebuf #(.N(N), .DW(DW), .IMG_W(IMG_W)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .pix_vld   (pix_vld),
        .pix_sof   (pix_sof),
        .pix_eol   (pix_eol),
        .pix_data  (pix_data),
        .dout      (dout),
        .dout_vld  (dout_vld),
        .dout_full (dout_full),
        .ovf_err   (ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*DW-1:0] dout;
        logic            full;
        logic            ovf;
    } exp_t;

    exp_t          q[$];
    int            n_chk  = 0;
    int            n_fail = 0;

    // Reference: whole-frame image addressed by absolute (row, col).
    logic [DW-1:0] img [int];
    int            m_r, m_c;
    logic          m_ovf;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_r   = 0;
        m_c   = 0;
        m_ovf = 1'b0;
        img.delete();
    endtask

    task automatic model_push(input logic sof, input logic eol, input logic [DW-1:0] d);
        exp_t e;
        logic [DW-1:0] v;
        if (sof) model_reset();
        e.dout = '0;
        e.dout[(N-1)*DW +: DW] = d;
        for (int j = 1; j < N; j++) begin
            if (m_r >= j) begin
                v = img[(m_r - j) * IMG_W + m_c];
            end else begin
`ifdef SOBEL5_LINEBUF_EDGE_REPLICATE_EN
                v = (m_r == 0) ? d : img[m_c];
`else
                v = '0;
`endif
            end
            e.dout[(N-1-j)*DW +: DW] = v;
        end
        e.full = (m_r >= N - 1);
        img[m_r * IMG_W + m_c] = d;
        if (!eol && m_c == IMG_W - 1) m_ovf = 1'b1;
        if (eol || m_c == IMG_W - 1) begin
            m_r++;
            m_c = 0;
        end else begin
            m_c++;
        end
        e.ovf = m_ovf;
        q.push_back(e);
    endtask

    task automatic send(input logic vld, input logic sof, input logic eol,
                        input logic [DW-1:0] d);
        @(posedge clk);
        #1;
        pix_vld  = vld;
        pix_sof  = vld & sof;
        pix_eol  = vld & eol;
        pix_data = d;
        if (vld) model_push(sof, eol, d);
    endtask

    // gap: 0 none, 1 every other cycle, 2 random. npix < 0 sends the whole frame.
    task automatic frame(input int w, input int rows, input bit rnd, input int gap,
                         input int npix, input bit sof_en);
        int cnt = 0;
        logic [DW-1:0] d;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < w; c++) begin
                if (npix >= 0 && cnt >= npix) return;
                d = rnd ? DW'($urandom) : DW'(r * 16 + c);
                send(1'b1, sof_en && r == 0 && c == 0, c == w - 1, d);
                cnt++;
                if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) send(1'b0, 1'b0, 1'b0, '0);
            end
        end
    endtask

    logic [N*DW-1:0] last;

    always @(negedge clk) begin
        exp_t e;
        if (rst_b) begin
            last = '0;
        end else if (dout_vld) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected dout_vld: got dout %0h, expected no output", dout);
            end else begin
                e = q.pop_front();
                chk("dout", 64'(dout), 64'(e.dout));
                chk("dout_full", 64'(dout_full), 64'(e.full));
                chk("ovf_err", 64'(ovf_err), 64'(e.ovf));
            end
            last = dout;
        end else begin
            chk("dout hold", 64'(dout), 64'(last));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_b    = 1'b1;
        pix_vld  = 1'b0;
        pix_sof  = 1'b0;
        pix_eol  = 1'b0;
        pix_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle dout", 64'(dout), 64'd0);
            chk("idle dout_vld", 64'(dout_vld), 64'd0);
            chk("idle dout_full", 64'(dout_full), 64'd0);
            chk("idle ovf_err", 64'(ovf_err), 64'd0);
        end

        // Patterned fill, then the same frame gapped.
        frame(8, 6, 1'b0, 0, -1, 1'b1);
        frame(8, 6, 1'b0, 1, -1, 1'b1);

        // Random frames with random gaps, including full-width lines.
        for (int f = 0; f < 4; f++) begin
            frame($urandom_range(3, IMG_W), $urandom_range(2, 7), 1'b1, 2, -1, 1'b1);
        end

        // Overflow: 20 pixels with no eol, then a fresh frame clears the flag.
        for (int i = 0; i < 20; i++) begin
            send(1'b1, i == 0, 1'b0, DW'($urandom));
            if (i % 3 == 2) send(1'b0, 1'b0, 1'b0, '0);
        end
        frame(6, 3, 1'b1, 0, -1, 1'b1);

        // Mid-frame sof at row 3 col 5 aborts into a new frame.
        frame(8, 6, 1'b0, 0, 3 * 8 + 5, 1'b1);
        frame(8, 6, 1'b1, 2, -1, 1'b1);

        // Reset at row 2 col 4; following pixels start row 0 without sof.
        frame(8, 6, 1'b0, 0, 2 * 8 + 4, 1'b1);
        @(posedge clk);
        #1;
        pix_vld = 1'b0;
        pix_sof = 1'b0;
        pix_eol = 1'b0;
        rst_b   = 1'b1;
        #1;
        chk("reset dout", 64'(dout), 64'd0);
        chk("reset dout_vld", 64'(dout_vld), 64'd0);
        chk("reset dout_full", 64'(dout_full), 64'd0);
        chk("reset ovf_err", 64'(ovf_err), 64'd0);
        q.delete();
        model_reset();
        @(posedge clk);
        #1 rst_b = 1'b0;
        frame(8, 6, 1'b1, 2, -1, 1'b0);
        frame(5, 7, 1'b1, 0, -1, 1'b1);

        repeat (3) send(1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        chk("scoreboard drained", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
